tenyr_boot_sequencer: RTL and testbench



---
 rtl/tenyr_boot_sequencer_pkg.sv | 20 ++
 rtl/tenyr_boot_sequencer_if.sv | 29 ++
 rtl/tenyr_sync2.sv | 27 ++
 rtl/tenyr_boot_sequencer.sv | 124 ++++++++++++
 tb/tb_tenyr_boot_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/tenyr_boot_sequencer_pkg.sv
// Shared halt-vector defines and sequencer state encodings for the Tenyr boot sequencer.
// Optional build macro used by the top: EXT_HALT_SYNC_EN.
`ifndef TENYR_BOOT_COMMON_DEFS
`define TENYR_BOOT_COMMON_DEFS
`define HALTTYPE [1:0]
`define HALT_TENYR 0
`define HALT_EXTERNAL 1
`endif

package tenyr_boot_sequencer_pkg;

    typedef logic [2:0] seq_state_t;

    localparam logic [2:0] S_RESET    = 3'd0;
    localparam logic [2:0] S_HOLDRST  = 3'd1;
    localparam logic [2:0] S_HOLDHALT = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

endpackage

// File: rtl/tenyr_boot_sequencer_if.sv
// Core-facing bundle of the boot sequencer: external halt request in, reset/halt/status out.
interface tenyr_boot_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             ext_halt_req;
    logic             core_reset_n;
    logic `HALTTYPE   halt;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] run_count;

    modport master (
        input  ext_halt_req,
        output core_reset_n,
        output halt,
        output running,
        output done,
        output run_count
    );

    modport slave (
        output ext_halt_req,
        input  core_reset_n,
        input  halt,
        input  running,
        input  done,
        input  run_count
    );
endinterface

// File: rtl/tenyr_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high clear.
module tenyr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/tenyr_boot_sequencer.sv
// Staged reset/halt release for the Tenyr core with a bounded run period and done flag.
// Build option: define EXT_HALT_SYNC_EN to pass ext_halt_req through a 2-flop synchronizer.
//
// state      | meaning
// S_RESET    | just out of reset, core held in reset and halted
// S_HOLDRST  | core reset still asserted, counting RESET_CYCLES
// S_HOLDHALT | core reset released, halt held until HALT_CYCLES
// S_RUN      | core running, run_count advancing unless externally halted
// S_DONE     | PERIODS run cycles elapsed, core halted until next reset
module tenyr_boot_sequencer
    import tenyr_boot_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES = 3,
    parameter int HALT_CYCLES  = 4,
    parameter int PERIODS      = 64,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    tenyr_boot_sequencer_if.master bus
);
    // Compare values are "last count before exit" so each phase lands on its absolute edge.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'((RESET_CYCLES < 2) ? 0 : RESET_CYCLES - 2);
    localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(HALT_CYCLES - RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_RUN  = CNT_W'((PERIODS == 0) ? 0 : PERIODS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic ext_src;

`ifdef EXT_HALT_SYNC_EN
    tenyr_sync2 u_ext_sync (
        .clk (clk),
        .rst (reset),
        .d   (bus.ext_halt_req),
        .q   (ext_src)
    );
`else
    assign ext_src = bus.ext_halt_req;
`endif

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] run_count_q, run_count_d;
    logic             core_reset_n_q, core_reset_n_d;
    logic `HALTTYPE   halt_q, halt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        seq_cnt_d   = '0;
        run_count_d = run_count_q;

        case (state_q)
            S_RESET: begin
                state_d = (RESET_CYCLES < 2) ? S_HOLDHALT : S_HOLDRST;
            end
            S_HOLDRST: begin
                seq_cnt_d = seq_cnt_q + CNT_ONE;
                if (seq_cnt_q == RST_LAST) state_d = S_HOLDHALT;
            end
            S_HOLDHALT: begin
                seq_cnt_d = seq_cnt_q + CNT_ONE;
                if (seq_cnt_q == HALT_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!halt_q[`HALT_EXTERNAL]) begin
                    if (PERIODS == 0) begin
                        // Unlimited mode saturates instead of wrapping.
                        if (run_count_q != '1) run_count_d = run_count_q + CNT_ONE;
                    end else begin
                        run_count_d = run_count_q + CNT_ONE;
                        if (run_count_q == LAST_RUN) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (state_d != state_q) seq_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they register alongside the state change.
    always_comb begin
        halt_d                 = '0;
        core_reset_n_d         = (state_d != S_RESET) && (state_d != S_HOLDRST);
        halt_d[`HALT_TENYR]    = (state_d != S_RUN);
        halt_d[`HALT_EXTERNAL] = (state_d == S_RUN) && ext_src;
        running_d              = (state_d == S_RUN) && !ext_src;
        done_d                 = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= S_RESET;
            seq_cnt_q           <= '0;
            run_count_q         <= '0;
            core_reset_n_q      <= 1'b0;
            halt_q              <= '0;
            halt_q[`HALT_TENYR] <= 1'b1;
            running_q           <= 1'b0;
            done_q              <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_cnt_q      <= seq_cnt_d;
            run_count_q    <= run_count_d;
            core_reset_n_q <= core_reset_n_d;
            halt_q         <= halt_d;
            running_q      <= running_d;
            done_q         <= done_d;
        end
    end

    assign bus.core_reset_n = core_reset_n_q;
    assign bus.halt         = halt_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.run_count    = run_count_q;
endmodule

// File: tb/tb_tenyr_boot_sequencer.sv
// Self-checking bench for tenyr_boot_sequencer: timing table, hand-written corner sequences,
// and randomized external-halt traffic checked against a cycle-count reference model.
module tb_tenyr_boot_sequencer;
    localparam int R  = 3;
    localparam int H  = 4;
    localparam int P  = 64;
    localparam int CW = 16;
`ifdef EXT_HALT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    always #5 clk = ~clk;

    tenyr_boot_sequencer_if #(.CNT_W(CW)) bus ();
    tenyr_boot_sequencer_if #(.CNT_W(4))  bus2 ();

    tenyr_boot_sequencer #(
        .RESET_CYCLES(R), .HALT_CYCLES(H), .PERIODS(P), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tenyr_boot_sequencer #(
        .RESET_CYCLES(R), .HALT_CYCLES(H), .PERIODS(0), .CNT_W(4)
    ) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derives from the edge count since reset release.
    int m_k;
    int m_rc;
    bit m_done;
    bit m_inrun;
    bit m_hext;
    bit m_q[$];

    task automatic model_reset();
        m_k = 0; m_rc = 0; m_done = 0; m_inrun = 0; m_hext = 0;
        m_q.delete();
        for (int i = 0; i < LAT - 1; i++) m_q.push_back(1'b0);
    endtask

    task automatic model_step(input bit req);
        bit delayed;
        if (m_inrun && !m_hext) begin
            m_rc++;
            if (m_rc == P) m_done = 1'b1;
        end
        m_k++;
        m_inrun = (m_k >= H) && !m_done;
        m_q.push_back(req);
        delayed = m_q.pop_front();
        m_hext  = m_inrun && delayed;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".core_reset_n"}, bus.core_reset_n, (m_k >= R));
        chk({tag, ".halt_tenyr"},   bus.halt[`HALT_TENYR], !m_inrun);
        chk({tag, ".halt_ext"},     bus.halt[`HALT_EXTERNAL], m_hext);
        chk({tag, ".running"},      bus.running, m_inrun && !m_hext);
        chk({tag, ".done"},         bus.done, m_done);
        chk({tag, ".run_count"},    bus.run_count, m_rc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_m(input string tag);
        bit req;
        req = bus.ext_halt_req;
        step();
        model_step(req);
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ext_halt_req = 1'b0;
        repeat (5) step();
        model_reset();
        reset = 1'b0;
    endtask

    typedef struct {
        int k;
        bit ext;
        bit crn;
        bit ht;
        bit run;
        int rc;
    } vec_t;

    vec_t tv[7];

    task automatic run_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            bus.ext_halt_req = tv[i].ext;
            for (int g = 0; g < 20 && m_k < tv[i].k; g++) step_m({tag, ".seq"});
            chk({tag, ".k"},            m_k, tv[i].k);
            chk({tag, ".core_reset_n"}, bus.core_reset_n, tv[i].crn);
            chk({tag, ".halt_tenyr"},   bus.halt[`HALT_TENYR], tv[i].ht);
            chk({tag, ".running"},      bus.running, tv[i].run);
            chk({tag, ".run_count"},    bus.run_count, tv[i].rc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".core_reset_n"}, bus.core_reset_n, 1'b0);
        chk({tag, ".halt_tenyr"},   bus.halt[`HALT_TENYR], 1'b1);
        chk({tag, ".halt_ext"},     bus.halt[`HALT_EXTERNAL], 1'b0);
        chk({tag, ".running"},      bus.running, 1'b0);
        chk({tag, ".done"},         bus.done, 1'b0);
        chk({tag, ".run_count"},    bus.run_count, 0);
    endtask

    initial begin
        int t0, e_first, hcnt, e_done, post;

        reset = 1'b1;
        reset2 = 1'b1;
        bus.ext_halt_req = 1'b0;
        bus2.ext_halt_req = 1'b0;

        tv[0] = '{k: 0, ext: 0, crn: 0, ht: 1, run: 0, rc: 0};
        tv[1] = '{k: 1, ext: 0, crn: 0, ht: 1, run: 0, rc: 0};
        tv[2] = '{k: 2, ext: 0, crn: 0, ht: 1, run: 0, rc: 0};
        tv[3] = '{k: 3, ext: 0, crn: 1, ht: 1, run: 0, rc: 0};
        tv[4] = '{k: 4, ext: 0, crn: 1, ht: 0, run: 1, rc: 0};
        tv[5] = '{k: 5, ext: 0, crn: 1, ht: 0, run: 1, rc: 1};
        tv[6] = '{k: 6, ext: 0, crn: 1, ht: 0, run: 1, rc: 2};

        // Release timing.
        do_reset();
        chk_reset_vals("rst_vals");
        run_table("release");

        // Full run with no halts: done exactly 64 cycles after running rose.
        for (int g = 0; g < 200 && !m_done; g++) step_m("run64");
        chk("run64.done_edge", m_k, H + P);
        chk("run64.done", bus.done, 1'b1);
        repeat (5) step_m("run64.hold");
        chk("run64.rc_hold", bus.run_count, P);
        chk("run64.halt_tenyr", bus.halt[`HALT_TENYR], 1'b1);
        chk("run64.core_reset_n", bus.core_reset_n, 1'b1);

        // Ten-cycle external halt mid-run.
        do_reset();
        for (int g = 0; g < 50 && m_k < H + 20; g++) step_m("exth.pre");
        chk("exth.rc_pre", bus.run_count, 20);
        t0 = m_k; e_first = -1; hcnt = 0; e_done = -1; post = 0;
        for (int i = 0; i < 200 && post < 3; i++) begin
            bus.ext_halt_req = (i < 10);
            step_m("exth");
            if (bus.halt[`HALT_EXTERNAL]) begin
                hcnt++;
                if (e_first < 0) e_first = m_k;
            end
            if (bus.done && e_done < 0) e_done = m_k;
            if (e_done >= 0) post++;
        end
        chk("exth.latency", e_first - t0, LAT);
        chk("exth.duration", hcnt, 10);
        chk("exth.done_edge", e_done, H + P + 10);
        chk("exth.rc_final", bus.run_count, P);

        // Async reset in RUN at run_count=20, then in DONE.
        do_reset();
        for (int g = 0; g < 50 && m_rc < 20; g++) step_m("rstrun.pre");
        chk("rstrun.rc", bus.run_count, 20);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rstrun.async");
        repeat (4) step();
        chk_reset_vals("rstrun.held");
        model_reset();
        reset = 1'b0;
        run_table("replay");
        for (int g = 0; g < 200 && !m_done; g++) step_m("rstdone.pre");
        chk("rstdone.done", bus.done, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rstdone.async");
        repeat (2) step();

        // Randomized bursty external halt requests against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.ext_halt_req = ~bus.ext_halt_req;
            step_m("rand");
        end
        bus.ext_halt_req = 1'b0;
        for (int g = 0; g < 200 && !m_done; g++) step_m("rand.tail");
        chk("rand.done", bus.done, 1'b1);

        // Unlimited mode, 4-bit counter: saturates at 15, never done.
        repeat (2) step();
        reset2 = 1'b0;
        repeat (H) step();
        chk("unl.running", bus2.running, 1'b1);
        chk("unl.rc0", bus2.run_count, 0);
        for (int j = 1; j <= 40; j++) begin
            step();
            if (j == 14 || j == 15 || j == 16 || j == 40)
                chk("unl.rc", bus2.run_count, (j < 15) ? j : 15);
        end
        chk("unl.done", bus2.done, 1'b0);
        chk("unl.halt_tenyr", bus2.halt[`HALT_TENYR], 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
